// File: rtl/fetch_sequencer.sv
// Program sequencer for the 8-bit core: owns the PC, fetches from the instruction ROM,
// and issues one-cycle datapath strobes from the EXECUTE phase of each instruction.
module fetch_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic              zero_in,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_instruction,
  output logic [DATA_W-1:0] ir,
  output logic [3:0]        operand,
  output logic              load_a,
  output logic              load_b,
  output logic              alu_add,
  output logic              load_out,
  output logic [ADDR_W-1:0] pc,
  output logic              running,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_PAUSE,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_LDB = 4'h1,
    OP_ADD = 4'h2,
    OP_OUT = 4'h3,
    OP_JMP = 4'h4,
    OP_JZ  = 4'h5,
    OP_HLT = 4'hF
  } opcode_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [DATA_W-1:0] ir_nxt;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] target;

  assign opcode      = ir[DATA_W-1 -: 4];
  assign operand     = ir[3:0];
  assign target      = ADDR_W'(operand);
  assign mem_address = pc;
  assign running     = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXECUTE);
  assign halted      = (state == S_HALT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  // Strobes come only from registered state/ir, so async reset drops them at once.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    load_a    = 1'b0;
    load_b    = 1'b0;
    alu_add   = 1'b0;
    load_out  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
        end
      end
      S_FETCH: begin
        ir_nxt    = mem_instruction;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        pc_nxt    = pc + ADDR_W'(1);
        state_nxt = step_mode ? S_PAUSE : S_FETCH;
        case (opcode)
          OP_LDA:  load_a   = 1'b1;
          OP_LDB:  load_b   = 1'b1;
          OP_ADD:  alu_add  = 1'b1;
          OP_OUT:  load_out = 1'b1;
          OP_JMP:  pc_nxt   = target;
          OP_JZ:   if (zero_in) pc_nxt = target;
          OP_HLT: begin
            pc_nxt    = pc;
            state_nxt = S_HALT;
          end
          default: ;
        endcase
      end
      S_PAUSE: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
        end else if (step) begin
          state_nxt = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: instruction-level reference model over a bench-owned ROM.
module tb_fetch_sequencer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       step_mode;
  logic       step;
  logic       zero_in;
  logic [3:0] mem_address;
  logic [7:0] mem_instruction;
  logic [7:0] ir;
  logic [3:0] operand;
  logic       load_a, load_b, alu_add, load_out;
  logic [3:0] pc;
  logic       running;
  logic       halted;
  logic [3:0] strobes;

  logic [7:0]  rom [16];
  int unsigned m_pc;
  int          checks;
  int          errors;
  int          cyc;
  int          exec_cyc;

  assign mem_instruction = rom[mem_address];
  assign strobes = {load_out, alu_add, load_b, load_a};

  fetch_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .step_mode(step_mode), .step(step),
    .zero_in(zero_in), .mem_address(mem_address), .mem_instruction(mem_instruction),
    .ir(ir), .operand(operand), .load_a(load_a), .load_b(load_b), .alu_add(alu_add),
    .load_out(load_out), .pc(pc), .running(running), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rules: opcodes 0..3 raise the strobe with that index, nothing else strobes.
  function automatic logic [3:0] exp_strobe(input logic [7:0] w);
    if (w[7:4] < 4'd4) return 4'(1 << w[7:4]);
    return 4'b0000;
  endfunction

  function automatic int unsigned next_pc(input int unsigned p, input logic [7:0] w, input bit z);
    if (w[7:4] == 4'h4 || (w[7:4] == 4'h5 && z)) return int'(w[3:0]);
    if (w[7:4] == 4'hF) return p;
    return (p + 1) % 16;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; step = 1'b0; step_mode = 1'b0; zero_in = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    m_pc = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_pc = 0;
  endtask

  // Runs one instruction from FETCH; optional start/step pulses land in the FETCH cycle.
  task automatic exec_one(input bit zr, input bit st_f, input bit sp_f, output bit hlt);
    logic [7:0]  w;
    int unsigned nxt;
    w = rom[m_pc];
    checks++;
    if (mem_address !== 4'(m_pc) || pc !== 4'(m_pc) || running !== 1'b1 || strobes !== 4'b0) begin
      errors++;
      $display("FAIL fetch: addr=%0d pc=%0d run=%b str=%b, expected addr=pc=%0d run=1 str=0000",
               mem_address, pc, running, strobes, m_pc);
    end
    start = st_f; step = sp_f;
    tick();
    start = 1'b0; step = 1'b0;
    zero_in = zr;
    checks++;
    if (ir !== w || running !== 1'b1 || strobes !== 4'b0) begin
      errors++;
      $display("FAIL decode: ir=%h run=%b str=%b, expected ir=%h run=1 str=0000", ir, running, strobes, w);
    end
    tick();
    exec_cyc = cyc;
    checks++;
    if (strobes !== exp_strobe(w) || operand !== w[3:0] || running !== 1'b1) begin
      errors++;
      $display("FAIL execute: ir=%h str=%b opnd=%h run=%b, expected str=%b opnd=%h run=1",
               ir, strobes, operand, running, exp_strobe(w), w[3:0]);
    end
    nxt = next_pc(m_pc, w, zr);
    tick();
    m_pc = nxt;
    hlt = (w[7:4] == 4'hF);
    if (hlt) begin
      checks++;
      if (halted !== 1'b1 || running !== 1'b0 || pc !== 4'(m_pc) || strobes !== 4'b0) begin
        errors++;
        $display("FAIL halt: halted=%b run=%b pc=%0d str=%b, expected 1 0 %0d 0000",
                 halted, running, pc, strobes, m_pc);
      end
    end else if (step_mode) begin
      checks++;
      if (running !== 1'b0 || halted !== 1'b0 || strobes !== 4'b0 || pc !== 4'(m_pc)) begin
        errors++;
        $display("FAIL pause_entry: run=%b halted=%b str=%b pc=%0d, expected 0 0 0000 %0d",
                 running, halted, strobes, pc, m_pc);
      end
    end
  endtask

  task automatic check_paused(input string name);
    checks++;
    if (running !== 1'b0 || halted !== 1'b0 || strobes !== 4'b0 || mem_address !== 4'(m_pc)) begin
      errors++;
      $display("FAIL %s: run=%b halted=%b str=%b addr=%0d, expected 0 0 0000 %0d",
               name, running, halted, strobes, mem_address, m_pc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 4'd0 || ir !== 8'h00 || strobes !== 4'b0 || running !== 1'b0 ||
        halted !== 1'b0 || mem_address !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: pc=%0d ir=%h str=%b run=%b halted=%b, expected 0 00 0000 0 0",
               pc, ir, strobes, running, halted);
    end
    step = 1'b1; step_mode = 1'b1; zero_in = 1'b1;
    tick(); tick();
    step = 1'b0; step_mode = 1'b0; zero_in = 1'b0;
    checks++;
    if (running !== 1'b0 || halted !== 1'b0 || pc !== 4'd0) begin
      errors++;
      $display("FAIL idle_ignores_step: run=%b halted=%b pc=%0d, expected 0 0 0", running, halted, pc);
    end
  endtask

  task automatic test_program();
    bit h;
    int base;
    logic [7:0] prog [5];
    prog = '{8'h05, 8'h12, 8'h20, 8'h30, 8'hF0};
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    for (int i = 0; i < 5; i++) rom[i] = prog[i];
    base = cyc;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      exec_one(1'b0, 1'b0, 1'b0, h);
      checks++;
      if (exec_cyc - base !== 3 * (i + 1)) begin
        errors++;
        $display("FAIL program_timing: instr %0d executed in cycle %0d, expected %0d",
                 i, exec_cyc - base, 3 * (i + 1));
      end
    end
    checks++;
    if (halted !== 1'b1 || pc !== 4'd4) begin
      errors++;
      $display("FAIL program_end: halted=%b pc=%0d, expected 1 4", halted, pc);
    end
  endtask

  task automatic test_wrap();
    bit h;
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    pulse_start();
    for (int i = 0; i < 16; i++) exec_one(1'($urandom_range(0, 1)), 1'b0, 1'b0, h);
    checks++;
    if (pc !== 4'd0 || running !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL wrap: pc=%0d run=%b halted=%b, expected 0 1 0", pc, running, halted);
    end
    exec_one(1'b0, 1'b0, 1'b0, h);
  endtask

  task automatic test_branch();
    bit h;
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    rom[0] = 8'h53;
    rom[3] = 8'h40;
    pulse_start();
    exec_one(1'b1, 1'b0, 1'b0, h);
    checks++;
    if (mem_address !== 4'd3) begin
      errors++;
      $display("FAIL jz_taken: addr=%0d, expected 3", mem_address);
    end
    exec_one(1'b0, 1'b0, 1'b0, h);
    checks++;
    if (mem_address !== 4'd0) begin
      errors++;
      $display("FAIL jmp: addr=%0d, expected 0", mem_address);
    end
    exec_one(1'b0, 1'b0, 1'b0, h);
    checks++;
    if (mem_address !== 4'd1) begin
      errors++;
      $display("FAIL jz_not_taken: addr=%0d, expected 1", mem_address);
    end
  endtask

  task automatic test_step();
    bit h;
    logic [3:0] ops [5];
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8};
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = {ops[$urandom_range(0, 4)], 4'($urandom_range(0, 15))};
    step_mode = 1'b1;
    pulse_start();
    exec_one(1'b0, 1'b0, 1'b0, h);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_paused("pause_hold");
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    exec_one(1'b0, 1'b0, 1'b1, h);
    tick(); tick();
    check_paused("step_in_fetch_not_kept");
    step = 1'b1;
    tick();
    step = 1'b0;
    exec_one(1'b0, 1'b0, 1'b0, h);
    start = 1'b1; step = 1'b1;
    tick();
    start = 1'b0; step = 1'b0;
    m_pc = 0;
    exec_one(1'b0, 1'b0, 1'b0, h);
    step_mode = 1'b0;
  endtask

  task automatic test_restart();
    bit h;
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    rom[0] = 8'h05;
    rom[1] = 8'h11;
    rom[2] = 8'hF0;
    pulse_start();
    exec_one(1'b0, 1'b0, 1'b0, h);
    exec_one(1'b0, 1'b1, 1'b0, h);
    exec_one(1'b0, 1'b0, 1'b0, h);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    checks++;
    if (halted !== 1'b1 || pc !== 4'd2 || running !== 1'b0) begin
      errors++;
      $display("FAIL halt_hold: halted=%b pc=%0d run=%b, expected 1 2 0", halted, pc, running);
    end
    pulse_start();
    checks++;
    if (pc !== 4'd0 || running !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL restart: pc=%0d run=%b halted=%b, expected 0 1 0", pc, running, halted);
    end
    exec_one(1'b0, 1'b0, 1'b0, h);
  endtask

  task automatic test_random();
    bit h;
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
    pulse_start();
    for (int n = 0; n < 80; n++) begin
      exec_one(1'($urandom_range(0, 1)), 1'b0, 1'b0, h);
      if (h) begin
        repeat ($urandom_range(0, 2)) tick();
        pulse_start();
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    rom[0] = 8'h05;
    pulse_start();
    tick(); tick();
    checks++;
    if (load_a !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: load_a=%b, expected 1", load_a);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (load_a !== 1'b0 || running !== 1'b0 || pc !== 4'd0 || ir !== 8'h00) begin
      errors++;
      $display("FAIL async_drop: load_a=%b run=%b pc=%0d ir=%h, expected 0 0 0 00",
               load_a, running, pc, ir);
    end
    tick();
    #2 reset_n = 1'b1;
    tick(); tick();
    checks++;
    if (running !== 1'b0 || halted !== 1'b0 || pc !== 4'd0 || ir !== 8'h00 || strobes !== 4'b0) begin
      errors++;
      $display("FAIL async_idle: run=%b halted=%b pc=%0d ir=%h str=%b, expected 0 0 0 00 0000",
               running, halted, pc, ir, strobes);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    reset_n = 1'b0; start = 1'b0; step = 1'b0; step_mode = 1'b0; zero_in = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    test_reset();
    test_program();
    test_wrap();
    test_branch();
    test_step();
    test_restart();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
